mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting directly downstream of the execute stage and upstream of write-back. It consumes the EX/MEM bundle (ALU result, store data, byte-write enables, opcode, destination register). It performs loads and stores against a single-port data memory through a request/acknowledge handshake, stalling execute while an access is outstanding. It produces a registered MEM/WB bundle with load data aligned and sign- or zero-extended.

---
 rtl/pipe_pkg.sv | 65 ++++++
 rtl/load_align.sv | 41 ++++
 rtl/mem_stage.sv | 206 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared across the pipeline stages.
//   - opcode encodings (common to decode, execute and memory)
//   - memory-stage fault codes
//   - mem_state_t, the memory-stage FSM state type
//   - small opcode classification and store-lane helpers
package pipe_pkg;

  localparam logic [5:0] OP_LB  = 6'd10;
  localparam logic [5:0] OP_LBU = 6'd11;
  localparam logic [5:0] OP_LH  = 6'd12;
  localparam logic [5:0] OP_LHU = 6'd13;
  localparam logic [5:0] OP_LW  = 6'd14;
  localparam logic [5:0] OP_SB  = 6'd15;
  localparam logic [5:0] OP_SH  = 6'd16;
  localparam logic [5:0] OP_SW  = 6'd17;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RETIRE = 2'd2
  } mem_state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // A store with no byte enabled is treated as misaligned: execute only
  // produces an empty mask when the address cannot hold the access.
  function automatic logic is_misaligned(input logic [5:0] op,
                                         input logic [1:0] addr_lo,
                                         input logic [3:0] we);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU:      bad = addr_lo[0];
      OP_LW:              bad = (addr_lo != 2'b00);
      OP_SB, OP_SH, OP_SW: bad = (we == 4'b0000);
      default:            bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Replicate store data across every lane the access could land on, so
  // the byte enables alone select the written bytes.
  function automatic logic [31:0] store_lanes(input logic [5:0] op,
                                              input logic [31:0] d);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{d[7:0]}};
      OP_SH:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extracts and extends load data from a read word.
//   rdata  in  32  word returned by data memory
//   offset in  2   byte offset of the access within the word
//   opcode in  6   load opcode (LB/LBU/LH/LHU/LW); others pass rdata
//   result out 32  aligned, sign- or zero-extended value
module load_align
  import pipe_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [5:0]  opcode,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halves are only legal at offsets 0 and 2; offset[0] is ignored here.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (opcode)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'd0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Accepts one EX/MEM bundle when idle, performs at most one data-memory
// access through a req/ack handshake, and emits a registered MEM/WB bundle.
//   clk, rst_n                 clock, async active-low reset
//   ex_valid / ex_ready        EX/MEM handshake (ready low stalls execute)
//   ex_opcode, ex_alu_out,
//   ex_store_data, ex_we,
//   ex_rd, ex_reg_write        EX/MEM bundle, sampled on the accept edge
//   dmem_req/wr/addr/be/wdata  memory request, held until dmem_ack
//   dmem_ack, dmem_rdata       completion and read data (same cycle)
//   wb_valid, wb_rd,
//   wb_reg_write, wb_data,
//   wb_fault                   MEM/WB bundle, wb_valid is a 1-cycle pulse
//
// state  | meaning
// IDLE   | ready for a bundle (ex_ready=1)
// ACCESS | memory request outstanding, waiting for ack or timeout
// RETIRE | wb_valid asserted for this one cycle
module mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [5:0]  ex_opcode,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_we,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_fault
);

  localparam int CNT_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(ACK_TIMEOUT);
  localparam logic TIMEOUT_EN = (ACK_TIMEOUT != 0);

  mem_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  // Bundle fields latched at accept
  logic [5:0]  opcode_q, opcode_nxt;
  logic [31:0] alu_q, alu_nxt;
  logic [4:0]  rd_q, rd_nxt;
  logic        reg_write_q, reg_write_nxt;

  logic        dmem_req_nxt, dmem_wr_nxt;
  logic [31:0] dmem_addr_nxt, dmem_wdata_nxt;
  logic [3:0]  dmem_be_nxt;
  logic        wb_valid_nxt, wb_reg_write_nxt;
  logic [4:0]  wb_rd_nxt;
  logic [31:0] wb_data_nxt;
  logic [1:0]  wb_fault_nxt;

  logic        ex_mem_op, ex_bad, ex_store;
  logic        expired;
  logic [31:0] load_result;

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (alu_q[1:0]),
    .opcode (opcode_q),
    .result (load_result)
  );

  assign ex_ready  = (state_q == IDLE);
  assign ex_store  = is_store(ex_opcode);
  assign ex_mem_op = is_load(ex_opcode) || ex_store;
  assign ex_bad    = is_misaligned(ex_opcode, ex_alu_out[1:0], ex_we);
  assign expired   = TIMEOUT_EN && (cnt_q == CNT_LIM);

  always_comb begin
    state_nxt        = state_q;
    cnt_nxt          = cnt_q;
    opcode_nxt       = opcode_q;
    alu_nxt          = alu_q;
    rd_nxt           = rd_q;
    reg_write_nxt    = reg_write_q;
    dmem_req_nxt     = dmem_req;
    dmem_wr_nxt      = dmem_wr;
    dmem_addr_nxt    = dmem_addr;
    dmem_be_nxt      = dmem_be;
    dmem_wdata_nxt   = dmem_wdata;
    wb_valid_nxt     = 1'b0;
    wb_rd_nxt        = wb_rd;
    wb_reg_write_nxt = wb_reg_write;
    wb_data_nxt      = wb_data;
    wb_fault_nxt     = wb_fault;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          opcode_nxt    = ex_opcode;
          alu_nxt       = ex_alu_out;
          rd_nxt        = ex_rd;
          reg_write_nxt = ex_reg_write;
          if (ex_mem_op && !ex_bad) begin
            state_nxt      = ACCESS;
            cnt_nxt        = '0;
            dmem_req_nxt   = 1'b1;
            dmem_wr_nxt    = ex_store;
            dmem_addr_nxt  = {ex_alu_out[31:2], 2'b00};
            dmem_be_nxt    = ex_store ? ex_we : 4'b1111;
            dmem_wdata_nxt = store_lanes(ex_opcode, ex_store_data);
          end else begin
            // Non-memory ops and misaligned memory ops retire directly.
            state_nxt        = RETIRE;
            wb_valid_nxt     = 1'b1;
            wb_rd_nxt        = ex_rd;
            wb_data_nxt      = ex_alu_out;
            wb_fault_nxt     = ex_bad ? FAULT_MISALIGN : FAULT_NONE;
            wb_reg_write_nxt = ex_bad ? 1'b0 : ex_reg_write;
          end
        end
      end

      ACCESS: begin
        // Ack takes priority over expiry in the same cycle.
        if (dmem_ack) begin
          state_nxt        = RETIRE;
          dmem_req_nxt     = 1'b0;
          dmem_wr_nxt      = 1'b0;
          wb_valid_nxt     = 1'b1;
          wb_rd_nxt        = rd_q;
          wb_fault_nxt     = FAULT_NONE;
          wb_reg_write_nxt = reg_write_q && is_load(opcode_q);
          wb_data_nxt      = is_load(opcode_q) ? load_result : alu_q;
        end else if (expired) begin
          state_nxt        = RETIRE;
          dmem_req_nxt     = 1'b0;
          dmem_wr_nxt      = 1'b0;
          wb_valid_nxt     = 1'b1;
          wb_rd_nxt        = rd_q;
          wb_fault_nxt     = FAULT_TIMEOUT;
          wb_reg_write_nxt = 1'b0;
          wb_data_nxt      = alu_q;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end

      RETIRE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt    = IDLE;
        dmem_req_nxt = 1'b0;
        dmem_wr_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      opcode_q     <= '0;
      alu_q        <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_wr      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      wb_fault     <= FAULT_NONE;
    end else begin
      state_q      <= state_nxt;
      cnt_q        <= cnt_nxt;
      opcode_q     <= opcode_nxt;
      alu_q        <= alu_nxt;
      rd_q         <= rd_nxt;
      reg_write_q  <= reg_write_nxt;
      dmem_req     <= dmem_req_nxt;
      dmem_wr      <= dmem_wr_nxt;
      dmem_addr    <= dmem_addr_nxt;
      dmem_be      <= dmem_be_nxt;
      dmem_wdata   <= dmem_wdata_nxt;
      wb_valid     <= wb_valid_nxt;
      wb_rd        <= wb_rd_nxt;
      wb_reg_write <= wb_reg_write_nxt;
      wb_data      <= wb_data_nxt;
      wb_fault     <= wb_fault_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, table-driven bench for mem_stage (ACK_TIMEOUT=4).
module tb_mem_stage;

  localparam int TMO    = 4;
  localparam int NO_ACK = 255;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic [3:0]  ex_we;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        dmem_req;
  logic        dmem_wr;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [1:0]  wb_fault;

  mem_stage #(.ACK_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_opcode     (ex_opcode),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .ex_we         (ex_we),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .dmem_req      (dmem_req),
    .dmem_wr       (dmem_wr),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_data       (wb_data),
    .wb_fault      (wb_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [3:0]  we;
    logic [4:0]  rd;
    logic        rw;
    int          ack_dly;    // ack in request cycle ack_dly+1; NO_ACK = never
    logic [31:0] rdata;
    int          req_cyc;    // expected number of cycles with dmem_req high
    logic        exp_wr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_rw;
    logic [1:0]  exp_fault;
  } vec_t;

  int n_vec;
  int n_err;
  int n_chk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [31:0] alu,
                              input logic [31:0] sdata, input logic [3:0] we,
                              input logic [4:0] rd, input logic rw,
                              input int ack_dly, input logic [31:0] rdata,
                              input int req_cyc, input logic exp_wr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                              input logic chk_data, input logic [31:0] exp_data,
                              input logic exp_rw, input logic [1:0] exp_fault);
    vec_t v;
    v.op = op; v.alu = alu; v.sdata = sdata; v.we = we; v.rd = rd; v.rw = rw;
    v.ack_dly = ack_dly; v.rdata = rdata; v.req_cyc = req_cyc;
    v.exp_wr = exp_wr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    v.chk_data = chk_data; v.exp_data = exp_data; v.exp_rw = exp_rw;
    v.exp_fault = exp_fault;
    return v;
  endfunction

  // One bundle: accept, service requests, check the retire pulse and
  // that the stage is ready again the cycle after.
  task automatic run_vec(input int idx, input vec_t v);
    int  req_cnt;
    int  wb_cyc;
    bit  seen;
    @(negedge clk);
    chk($sformatf("v%0d ready_before", idx), {31'd0, ex_ready}, 32'd1);
    ex_valid      = 1'b1;
    ex_opcode     = v.op;
    ex_alu_out    = v.alu;
    ex_store_data = v.sdata;
    ex_we         = v.we;
    ex_rd         = v.rd;
    ex_reg_write  = v.rw;
    @(negedge clk);
    ex_valid   = 1'b0;
    ex_alu_out = 32'hFFFF_FFFF;
    req_cnt = 0;
    wb_cyc  = 0;
    seen    = 1'b0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      if (cyc > 1) @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      if (dmem_req) begin
        req_cnt++;
        chk($sformatf("v%0d dmem_addr", idx), dmem_addr, {v.alu[31:2], 2'b00});
        chk($sformatf("v%0d dmem_be", idx), {28'd0, dmem_be}, {28'd0, v.exp_be});
        chk($sformatf("v%0d dmem_wr", idx), {31'd0, dmem_wr}, {31'd0, v.exp_wr});
        chk($sformatf("v%0d dmem_wdata", idx), dmem_wdata, v.exp_wdata);
        chk($sformatf("v%0d ready_busy", idx), {31'd0, ex_ready}, 32'd0);
        if (v.ack_dly != NO_ACK && req_cnt == v.ack_dly + 1) begin
          dmem_ack   = 1'b1;
          dmem_rdata = v.rdata;
        end
      end
      if (wb_valid) begin
        seen   = 1'b1;
        wb_cyc = cyc;
      end
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL v%0d wb_valid: got none within 20 cycles expected a pulse", idx);
    end else begin
      chk($sformatf("v%0d wb_cycle", idx), wb_cyc, v.req_cyc + 1);
      chk($sformatf("v%0d req_cycles", idx), req_cnt, v.req_cyc);
      chk($sformatf("v%0d wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.rd});
      chk($sformatf("v%0d wb_reg_write", idx), {31'd0, wb_reg_write}, {31'd0, v.exp_rw});
      chk($sformatf("v%0d wb_fault", idx), {30'd0, wb_fault}, {30'd0, v.exp_fault});
      if (v.chk_data) chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    chk($sformatf("v%0d wb_pulse_end", idx), {31'd0, wb_valid}, 32'd0);
    chk($sformatf("v%0d ready_after", idx), {31'd0, ex_ready}, 32'd1);
    n_vec++;
  endtask

  vec_t vecs[14];

  initial begin
    n_vec = 0; n_err = 0; n_chk = 0;
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_opcode = '0; ex_alu_out = '0; ex_store_data = '0;
    ex_we = '0; ex_rd = '0; ex_reg_write = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;

    //            op     alu           sdata         we      rd     rw  ack     rdata         req  wr  be      wdata         cd  data          rw  fault
    vecs[0]  = mk(6'd1,  32'h1234_5678, 32'h0,        4'h0,   5'd5,  1, NO_ACK, 32'h0,        0,   0,  4'h0,   32'h0,        1,  32'h1234_5678, 1, 2'b00);
    vecs[1]  = mk(6'd10, 32'h0000_0103, 32'h0,        4'h0,   5'd7,  1, 0,      32'h80FF_0000, 1,  0,  4'hF,   32'h0,        1,  32'hFFFF_FF80, 1, 2'b00);
    vecs[2]  = mk(6'd11, 32'h0000_0103, 32'h0,        4'h0,   5'd8,  1, 0,      32'h80FF_0000, 1,  0,  4'hF,   32'h0,        1,  32'h0000_0080, 1, 2'b00);
    vecs[3]  = mk(6'd16, 32'h0000_0202, 32'hDEAD_BEEF, 4'hC,  5'd0,  0, 3,      32'h0,        4,   1,  4'hC,   32'hBEEF_BEEF, 0, 32'h0,        0, 2'b00);
    vecs[4]  = mk(6'd14, 32'h0000_0006, 32'h0,        4'h0,   5'd9,  1, NO_ACK, 32'h0,        0,   0,  4'h0,   32'h0,        0,  32'h0,        0, 2'b01);
    vecs[5]  = mk(6'd14, 32'h0000_0040, 32'h0,        4'h0,   5'd10, 1, NO_ACK, 32'h0,        5,   0,  4'hF,   32'h0,        0,  32'h0,        0, 2'b10);
    vecs[6]  = mk(6'd14, 32'h0000_0040, 32'h0,        4'h0,   5'd11, 1, 4,      32'hCAFE_BABE, 5,  0,  4'hF,   32'h0,        1,  32'hCAFE_BABE, 1, 2'b00);
    vecs[7]  = mk(6'd12, 32'h0000_0012, 32'h0,        4'h0,   5'd12, 1, 1,      32'h8001_7FFF, 2,  0,  4'hF,   32'h0,        1,  32'hFFFF_8001, 1, 2'b00);
    vecs[8]  = mk(6'd13, 32'h0000_0010, 32'h0,        4'h0,   5'd13, 1, 2,      32'h8001_F00D, 3,  0,  4'hF,   32'h0,        1,  32'h0000_F00D, 1, 2'b00);
    vecs[9]  = mk(6'd12, 32'h0000_0011, 32'h0,        4'h0,   5'd14, 1, NO_ACK, 32'h0,        0,   0,  4'h0,   32'h0,        0,  32'h0,        0, 2'b01);
    vecs[10] = mk(6'd15, 32'h0000_0301, 32'h0000_00A5, 4'h2,  5'd0,  0, 0,      32'h0,        1,   1,  4'h2,   32'hA5A5_A5A5, 0, 32'h0,        0, 2'b00);
    vecs[11] = mk(6'd17, 32'h0000_0400, 32'h1122_3344, 4'h0,  5'd0,  0, NO_ACK, 32'h0,        0,   0,  4'h0,   32'h0,        0,  32'h0,        0, 2'b01);
    vecs[12] = mk(6'd17, 32'h0000_0404, 32'h1122_3344, 4'hF,  5'd0,  0, 1,      32'h0,        2,   1,  4'hF,   32'h1122_3344, 0, 32'h0,        0, 2'b00);
    vecs[13] = mk(6'd10, 32'h0000_0001, 32'h0,        4'h0,   5'd15, 1, 0,      32'h0000_7F00, 1,  0,  4'hF,   32'h0,        1,  32'h0000_007F, 1, 2'b00);

    // Reset values
    #12;
    chk("rst dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst dmem_wr", {31'd0, dmem_wr}, 32'd0);
    chk("rst dmem_addr", dmem_addr, 32'd0);
    chk("rst dmem_be", {28'd0, dmem_be}, 32'd0);
    chk("rst dmem_wdata", dmem_wdata, 32'd0);
    chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst wb_fault", {30'd0, wb_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst ex_ready", {31'd0, ex_ready}, 32'd1);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Back-to-back non-memory ops with ex_valid held: 1 per 2 cycles,
    // inputs ignored while not ready, stray ack ignored outside ACCESS.
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = 6'd1; ex_alu_out = 32'hAAAA_0001;
    ex_rd = 5'd3; ex_reg_write = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    chk("b2b wb_valid_1", {31'd0, wb_valid}, 32'd1);
    chk("b2b wb_data_1", wb_data, 32'hAAAA_0001);
    chk("b2b ready_1", {31'd0, ex_ready}, 32'd0);
    chk("b2b no_req_1", {31'd0, dmem_req}, 32'd0);
    ex_alu_out = 32'hBBBB_0002; ex_rd = 5'd4;
    @(negedge clk);
    chk("b2b wb_valid_2", {31'd0, wb_valid}, 32'd0);
    chk("b2b ready_2", {31'd0, ex_ready}, 32'd1);
    @(negedge clk);
    ex_valid = 1'b0; dmem_ack = 1'b0;
    chk("b2b wb_valid_3", {31'd0, wb_valid}, 32'd1);
    chk("b2b wb_data_3", wb_data, 32'hBBBB_0002);
    chk("b2b wb_rd_3", {27'd0, wb_rd}, 32'd4);
    n_vec++;
    @(negedge clk);

    // Reset in the middle of an access
    @(negedge clk);
    ex_valid = 1'b1; ex_opcode = 6'd14; ex_alu_out = 32'h0000_0080;
    ex_rd = 5'd6; ex_reg_write = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    @(negedge clk);
    chk("rstmid req_before", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid req_dropped", {31'd0, dmem_req}, 32'd0);
    chk("rstmid wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rstmid no_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rstmid no_req", {31'd0, dmem_req}, 32'd0);
      chk("rstmid ready", {31'd0, ex_ready}, 32'd1);
    end
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
